// File: rtl/lift_pkg.sv
// Shared definitions for the lift call panel: controller floor codes,
// physical floor / direction decoding and the panel FSM state enum.
package lift_pkg;

    localparam int NUM_FLOORS = 4;

    // Encoded floor/direction state reported by the lift controller.
    typedef enum logic [2:0] {
        FL_A  = 3'd0,
        FL_BU = 3'd1,
        FL_BD = 3'd2,
        FL_CU = 3'd3,
        FL_CD = 3'd4,
        FL_D  = 3'd5
    } floor_code_e;

    // Physical floor index plus a flag saying the code was a legal one.
    typedef struct packed {
        logic       valid;
        logic [1:0] flr;
    } phys_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_DWELL   = 2'd2
    } state_e;

    // Collapse the up/down variants of B and C onto one physical floor.
    // Codes 6/7 report floor 0 with valid cleared so they never match a target.
    function automatic phys_t phys_floor(input logic [2:0] code);
        phys_t p;
        p.valid = 1'b1;
        p.flr   = 2'd0;
        case (code)
            FL_A:         p.flr = 2'd0;
            FL_BU, FL_BD: p.flr = 2'd1;
            FL_CU, FL_CD: p.flr = 2'd2;
            FL_D:         p.flr = 2'd3;
            default:      p.valid = 1'b0;
        endcase
        return p;
    endfunction

    // Travel direction implied by the code; invalid codes count as up.
    function automatic logic dir_up(input logic [2:0] code);
        return !(code == FL_BD || code == FL_CD || code == FL_D);
    endfunction

endpackage

// File: rtl/lift_call_select.sv
// Combinational SCAN arbiter: picks the pending call at the current floor,
// else the nearest one ahead in the travel direction, else the nearest behind.
module lift_call_select
    import lift_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [1:0]            cur_floor,
    input  logic                  up,
    output logic [1:0]            target
);

    logic       found;
    logic [2:0] cand;

    // Scan outward from the current floor; bit 2 of cand flags off-the-shaft.
    always_comb begin
        target = cur_floor;
        found  = pending[cur_floor];
        cand   = '0;
        // strictly ahead, nearest first
        for (int d = 1; d < NUM_FLOORS; d++) begin
            cand = up ? ({1'b0, cur_floor} + 3'(d)) : ({1'b0, cur_floor} - 3'(d));
            if (!found && !cand[2] && pending[cand[1:0]]) begin
                target = cand[1:0];
                found  = 1'b1;
            end
        end
        // behind, nearest first
        for (int d = 1; d < NUM_FLOORS; d++) begin
            cand = up ? ({1'b0, cur_floor} - 3'(d)) : ({1'b0, cur_floor} + 3'(d));
            if (!found && !cand[2] && pending[cand[1:0]]) begin
                target = cand[1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_call_panel.sv
// Request-side front end of the four-floor lift: latches calls, presents one
// request at a time chosen by SCAN, holds it through the door dwell and then
// clears the served call. Every output comes straight from a flop.
module lift_call_panel
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [2:0] floor,
    output logic       ra,
    output logic       rb,
    output logic       rc,
    output logic       rd,
    output logic [3:0] pending,
    output logic       door_open,
    output logic       arrived
);

    localparam int                CNT_W    = $clog2(DWELL_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       req_q, req_d;
    logic             door_open_q, door_open_d;
    logic             arrived_q, arrived_d;

    phys_t      phys;
    logic       up;
    logic [1:0] sel_target;

    assign phys = phys_floor(floor);
    assign up   = dir_up(floor);

    lift_call_select u_select (
        .pending   (pending_q),
        .cur_floor (phys.flr),
        .up        (up),
        .target    (sel_target)
    );

    // Next-state logic: call latch, FSM, dwell counter and registered outputs.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        arrived_d = 1'b0;
        // new presses only become visible to selection next cycle
        pending_d = pending_q | btn;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    target_d = sel_target;
                    state_d  = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // target is frozen here; an invalid floor code never matches
                if (phys.valid && phys.flr == target_q) begin
                    cnt_d   = '0;
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (cnt_q == CNT_LAST) begin
                    // clearing overrides a press of the same button this edge
                    pending_d[target_q] = 1'b0;
                    arrived_d           = 1'b1;
                    state_d             = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_d       = (state_d != ST_IDLE) ? (4'b0001 << target_d) : 4'b0000;
        door_open_d = (state_d == ST_DWELL);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            req_q       <= '0;
            door_open_q <= 1'b0;
            arrived_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            req_q       <= req_d;
            door_open_q <= door_open_d;
            arrived_q   <= arrived_d;
        end
    end

    assign {rd, rc, rb, ra} = req_q;
    assign pending          = pending_q;
    assign door_open        = door_open_q;
    assign arrived          = arrived_q;

endmodule
